// File: rtl/prog_clk_div_if.sv
// Control and status bundle for the programmable clock divider.
// The master side drives the controls and the slave side (the divider) drives the status.
interface prog_clk_div_if #(
  parameter int W = 8
) ();
  logic         clr;
  logic         en;
  logic         ld_div;
  logic [W-1:0] div_in;
  logic [W-1:0] cnt;
  logic [W-1:0] div_act;
  logic         tc;
  logic         sq;
  logic         pend_v;
  logic         err;

  modport master (
    output clr, en, ld_div, div_in,
    input  cnt, div_act, tc, sq, pend_v, err
  );

  modport slave (
    input  clr, en, ld_div, div_in,
    output cnt, div_act, tc, sq, pend_v, err
  );
endinterface

// File: rtl/prog_clk_div.sv
// Programmable modulo-N counter with a square-wave output.
// A new divisor is shadowed and only takes effect when the count returns to zero.
module prog_clk_div #(
  parameter int W       = 8,
  parameter int DEF_DIV = 6
) (
  input  logic              clk,
  input  logic              rst_b,
  prog_clk_div_if.slave     bus
);

  localparam logic [W-1:0] DEF_V   = W'(DEF_DIV);
  localparam logic [W-1:0] MIN_DIV = W'(2);
  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W-1:0] ZERO    = W'(0);

  // Divisors below two cannot produce a period, so they are raised to two.
  function automatic logic [W-1:0] clamp_div(input logic [W-1:0] v);
    if (v < MIN_DIV) begin
      return MIN_DIV;
    end else begin
      return v;
    end
  endfunction

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_act_q, div_act_d;
  logic [W-1:0] shadow_q, shadow_d;
  logic         pend_q, pend_d;
  logic         err_q, err_d;

  logic         wrap_s;
  logic         apply_s;
  logic [W-1:0] div_clamp_s;
  logic [W:0]   half_s;

  assign wrap_s      = bus.en & ~bus.clr & (cnt_q == (div_act_q - ONE));
  assign apply_s     = wrap_s | bus.clr;
  assign div_clamp_s = clamp_div(bus.div_in);
  assign half_s      = ({1'b0, div_act_q} + {{W{1'b0}}, 1'b1}) >> 1;

  // Next-state for the counter, divisor, shadow and status flags.
  always_comb begin
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    shadow_d  = shadow_q;
    pend_d    = pend_q;
    err_d     = 1'b0;

    if (bus.clr) begin
      cnt_d = ZERO;
    end else if (bus.en) begin
      if (wrap_s) begin
        cnt_d = ZERO;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end

    if (bus.ld_div) begin
      shadow_d = div_clamp_s;
      err_d    = (bus.div_in < MIN_DIV) ? 1'b1 : 1'b0;
    end else begin
      shadow_d = shadow_q;
    end

    // A load arriving on the apply edge wins over any older pending value.
    if (apply_s) begin
      pend_d = 1'b0;
      if (bus.ld_div) begin
        div_act_d = div_clamp_s;
      end else if (pend_q) begin
        div_act_d = shadow_q;
      end else begin
        div_act_d = div_act_q;
      end
    end else begin
      div_act_d = div_act_q;
      if (bus.ld_div) begin
        pend_d = 1'b1;
      end else begin
        pend_d = pend_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q     <= ZERO;
      div_act_q <= DEF_V;
      shadow_q  <= DEF_V;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
    end
  end

  assign bus.cnt     = cnt_q;
  assign bus.div_act = div_act_q;
  assign bus.pend_v  = pend_q;
  assign bus.err     = err_q;
  assign bus.tc      = (cnt_q == ZERO);
  assign bus.sq      = ({1'b0, cnt_q} < half_s);

endmodule

// File: tb/tb_prog_clk_div.sv
// Randomized scoreboard bench for prog_clk_div against an arithmetic reference model.
module tb_prog_clk_div;

  logic clk;
  logic rst_b;

  prog_clk_div_if #(.W(8)) bus ();

  prog_clk_div #(.W(8), .DEF_DIV(6)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  typedef struct {
    int cnt;
    int div;
    int tc;
    int sq;
    int pend;
    int err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  int m_cnt, m_div, m_sh, m_pend, m_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic exp_t snap();
    exp_t x;
    x.cnt  = m_cnt;
    x.div  = m_div;
    x.tc   = (m_cnt == 0) ? 1 : 0;
    x.sq   = (m_cnt < (m_div + 1) / 2) ? 1 : 0;
    x.pend = m_pend;
    x.err  = m_err;
    return x;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_div = 6; m_sh = 6; m_pend = 0; m_err = 0;
  endtask

  task automatic check_now(input string tag);
    exp_t x;
    x = snap();
    chk({tag, "_cnt"},  int'(bus.cnt),     x.cnt);
    chk({tag, "_div"},  int'(bus.div_act), x.div);
    chk({tag, "_pend"}, int'(bus.pend_v),  x.pend);
    chk({tag, "_err"},  int'(bus.err),     x.err);
    chk({tag, "_tc"},   int'(bus.tc),      x.tc);
    chk({tag, "_sq"},   int'(bus.sq),      x.sq);
  endtask

  // One clock of stimulus; the expected post-edge state is queued for the monitor.
  task automatic step(input bit c, input bit e, input bit l, input int d);
    bit wrap, app;
    int dc;
    bus.clr    = c;
    bus.en     = e;
    bus.ld_div = l;
    bus.div_in = d[7:0];
    wrap = e && !c && (m_cnt == m_div - 1);
    app  = wrap || c;
    dc   = (d < 2) ? 2 : d;
    m_err = (l && d < 2) ? 1 : 0;
    if (c) m_cnt = 0;
    else if (e) m_cnt = (m_cnt + 1) % m_div;
    if (app) begin
      if (l) m_div = dc;
      else if (m_pend != 0) m_div = m_sh;
      m_pend = 0;
    end else if (l) begin
      m_pend = 1;
    end
    if (l) m_sh = dc;
    @(posedge clk);
    sb.push_back(snap());
    #2;
  endtask

  // Reset pulse between edges, checked before the following edge.
  task automatic areset();
    @(negedge clk);
    #1;
    rst_b = 1'b0;
    model_reset();
    #1;
    check_now("areset");
    rst_b = 1'b1;
  endtask

  // Monitor: compares the DUT against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      chk("cnt",  int'(bus.cnt),     x.cnt);
      chk("div",  int'(bus.div_act), x.div);
      chk("tc",   int'(bus.tc),      x.tc);
      chk("sq",   int'(bus.sq),      x.sq);
      chk("pend", int'(bus.pend_v),  x.pend);
      chk("err",  int'(bus.err),     x.err);
    end
  end

  initial begin
    rst_b      = 1'b0;
    bus.clr    = 1'b0;
    bus.en     = 1'b0;
    bus.ld_div = 1'b0;
    bus.div_in = 8'd0;
    model_reset();
    @(posedge clk);
    #2;
    check_now("reset");
    rst_b = 1'b1;

    // Default period of six.
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b0, 0);
    // Load 3 mid-period (count is now 2).
    step(1'b0, 1'b1, 1'b1, 3);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 0);
    // Illegal divisor clamps to 2.
    step(1'b0, 1'b1, 1'b1, 1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 0);
    // Odd divisor.
    step(1'b0, 1'b1, 1'b1, 5);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 0);
    // Clear coinciding with a load at count 4.
    for (int i = 0; i < 10 && m_cnt != 4; i++) step(1'b0, 1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 1'b1, 4);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);
    // Asynchronous reset at count 3 with a load pending.
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 9);
    for (int i = 0; i < 10 && m_cnt != 3; i++) step(1'b0, 1'b1, 1'b0, 0);
    areset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bit c, e, l;
      int d;
      c = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 4) != 0);
      l = ($urandom_range(0, 9) == 0);
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 10));
      if ($urandom_range(0, 99) == 0) areset();
      step(c, e, l, d);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_clk_div.md
PROG_CLK_DIV -- requirements
Module: prog_clk_div

Parameters
REQ-001 The block SHALL have parameter W, default 8: width of the counter and divisor.
REQ-002 The block SHALL have parameter DEF_DIV, default 6: divisor after reset; legal range 2..2^W-1.

Interface
REQ-003 The block SHALL have input clk (1 bit): clock; all state updates on its rising edge.
REQ-004 The block SHALL have input rst_b (1 bit): reset, asynchronous, active-low.
REQ-005 The block SHALL have input clr (1 bit): synchronous clear of the counter.
REQ-006 The block SHALL have input en (1 bit): count enable.
REQ-007 The block SHALL have input ld_div (1 bit): request to load a new divisor.
REQ-008 The block SHALL have input div_in (W bits): requested divisor N.
REQ-009 The block SHALL have output cnt (W bits): current count.
REQ-010 The block SHALL have output div_act (W bits): active divisor.
REQ-011 The block SHALL have output tc (1 bit): terminal/zero indication.
REQ-012 The block SHALL have output sq (1 bit): divided square wave.
REQ-013 The block SHALL have output pend_v (1 bit): a divisor load is pending.
REQ-014 The block SHALL have output err (1 bit): one-cycle flag for an illegal divisor request.

Function
REQ-015 With en=1, clr=0, cnt SHALL step 0,1,…,div_act-1,0 (one step per clk); with en=0, cnt SHALL hold.
REQ-016 The wrap event SHALL be en=1 & clr=0 & cnt==div_act-1.
REQ-017 tc SHALL equal (cnt==0), decoded from registered cnt, independent of en.
REQ-018 sq SHALL equal (cnt < (div_act+1)/2), integer division: even N gives 50% duty; odd N is high one extra cycle.
REQ-019 On ld_div=1, div_in SHALL be captured into a shadow register and pend_v set on the next edge; a later ld_div before application overwrites the shadow (last wins).
REQ-020 A pending divisor SHALL be copied to div_act only on a wrap event or a clr cycle, with pend_v cleared on the same edge; div_act never changes mid-period.
REQ-021 If ld_div coincides with a wrap or clr, div_in SHALL be applied to div_act directly on that edge and pend_v SHALL be 0 afterwards.
REQ-022 A div_in value <2 SHALL be stored as 2, and err SHALL be 1 for exactly the cycle after the ld_div edge; otherwise err SHALL be 0.
REQ-023 clr=1 SHALL force cnt to 0 on the next edge regardless of en; clr SHALL have priority over counting.
REQ-024 Since div_act changes only when cnt becomes 0, cnt SHALL never be ≥ div_act.
REQ-025 When div_act=2 and en=1, sq SHALL toggle every cycle and tc SHALL be high on alternate cycles.

Reset
REQ-026 On rst_b=0, immediately and without waiting for clk: cnt=0, div_act=DEF_DIV, shadow=DEF_DIV, pend_v=0, err=0; hence tc=1 and sq=1.
REQ-027 Reset asserted mid-count SHALL discard any pending divisor.
REQ-028 After rst_b deasserts, counting SHALL begin on the first rising edge with en=1.

Verification
REQ-029 Scenario 1 (default count): rst, then en=1 for 14 cycles -> cnt 0..5 repeating; tc high at cnt=0 only (period 6); sq high for cnt 0..2.
REQ-030 Scenario 2 (load mid-period): ld_div with div_in=3 at cnt=2 -> pend_v=1 from the next cycle; cnt continues 3,4,5,0; div_act=3 at that wrap; pend_v=0; thereafter period 3.
REQ-031 Scenario 3 (illegal divisor): ld_div with div_in=1 -> err pulse one cycle; div_act becomes 2 at the next wrap; sq toggles every cycle.
REQ-032 Scenario 4 (odd divisor): div_act=5 -> sq high at cnt 0,1,2 and low at cnt 3,4.
REQ-033 Scenario 5 (clear with load): clr=1 & ld_div=1 with div_in=4 at cnt=4 and en=1 -> next cnt=0, div_act=4, pend_v=0; en=0 with clr=1 also yields cnt=0.
REQ-034 Scenario 6 (async reset): rst_b low between edges at cnt=3 with a divisor pending -> cnt=0, div_act=6, pend_v=0 before the next clk edge.
